bubble_host_reader: RTL and testbench

Host-side counterpart of the bubble memory emulator core. It drives the bubble control strobes (nBSS, nBSEN, nREPEN, nBOOTEN, nSWAPEN) the way the game board's controller does, samples DOUT0/DOUT1 against the emulator's 4 MHz CLKOUT, and packs the bit stream into bytes behind a valid/ready handshake. It is used in the ModelSim bench and the bring-up build to read pages back from the emulator without a real game PCB.

---
 rtl/bubble_host_reader.sv | 178 +++++++++++++++++
 tb/tb_bubble_host_reader.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bubble_host_reader.sv
`default_nettype none
// ============================================================================
// bubble_host_reader : drives the bubble control strobes like the game board,
//                      samples DOUT0/DOUT1 on CLKOUT ticks, packs bytes (LSB first).
// Rev 1.0
// ============================================================================
module bubble_host_reader #(
  parameter int SETTLE_TICKS = 8,
  parameter int PAGE_TICKS   = 512,
  parameter int GAP_TICKS    = 4
) (
  input  logic        MCLK,
  input  logic        MRST,
  input  logic        START,
  input  logic        BOOTMODE,
  input  logic [11:0] PAGECNT,
  input  logic        CLKOUT,
  input  logic        DOUT0,
  input  logic        DOUT1,
  output logic        nBSS,
  output logic        nBSEN,
  output logic        nREPEN,
  output logic        nBOOTEN,
  output logic        nSWAPEN,
  output logic [7:0]  RDDATA,
  output logic        RDVALID,
  input  logic        RDREADY,
  output logic        BUSY,
  output logic        DONE,
  output logic        OVERRUN
);

  localparam int MAX_SP    = (SETTLE_TICKS > PAGE_TICKS) ? SETTLE_TICKS : PAGE_TICKS;
  localparam int MAX_TICKS = (MAX_SP > GAP_TICKS) ? MAX_SP : GAP_TICKS;
  localparam int TW        = $clog2(MAX_TICKS + 1);

  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_TICKS - 1);
  localparam logic [TW-1:0] PAGE_LAST   = TW'(PAGE_TICKS - 1);
  localparam logic [TW-1:0] GAP_LAST    = TW'(GAP_TICKS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_PAGE   = 3'd2;
  localparam logic [2:0] S_GAP    = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

  logic          sync1_q, sync2_q, sync3_q, tick_q;
  logic          sync1_d, sync2_d, sync3_d, tick_d;
  logic [2:0]    state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [11:0]   pages_q, pages_d;
  logic          boot_q, boot_d;
  logic [5:0]    shift_q, shift_d;
  logic [7:0]    rddata_q, rddata_d;
  logic          rdvalid_q, rdvalid_d;
  logic          overrun_q, overrun_d;
  logic          byte_done;
  logic [7:0]    byte_val;

  always_comb begin
    sync1_d   = CLKOUT;
    sync2_d   = sync1_q;
    sync3_d   = sync2_q;
    tick_d    = sync2_q & ~sync3_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    pages_d   = pages_q;
    boot_d    = boot_q;
    shift_d   = shift_q;
    rddata_d  = rddata_q;
    rdvalid_d = rdvalid_q;
    overrun_d = overrun_q;
    byte_done = 1'b0;
    byte_val  = {~DOUT1, ~DOUT0, shift_q};

    case (state_q)
      S_IDLE: begin
        if (START && (PAGECNT != 12'd0)) begin
          state_d   = S_SETUP;
          pages_d   = PAGECNT;
          boot_d    = BOOTMODE;
          overrun_d = 1'b0;
          cnt_d     = '0;
        end
      end
      S_SETUP: begin
        if (tick_q) begin
          if (cnt_q == SETTLE_LAST) begin
            state_d = S_PAGE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_PAGE: begin
        if (tick_q) begin
          // Newest pair enters at the top; after four ticks tick 0 sits in bits [1:0].
          shift_d   = {~DOUT1, ~DOUT0, shift_q[5:2]};
          byte_done = (cnt_q[1:0] == 2'b11);
          if (cnt_q == PAGE_LAST) begin
            cnt_d   = '0;
            pages_d = pages_q - 12'd1;
            state_d = (pages_q == 12'd1) ? S_FINISH : S_GAP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_GAP: begin
        if (tick_q) begin
          if (cnt_q == GAP_LAST) begin
            state_d = S_PAGE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    if (rdvalid_q && RDREADY) rdvalid_d = 1'b0;
    // A byte landing on a full, unaccepted holding register is dropped.
    if (byte_done) begin
      if (!rdvalid_q || RDREADY) begin
        rddata_d  = byte_val;
        rdvalid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge MCLK) begin
    if (MRST) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      sync3_q   <= 1'b0;
      tick_q    <= 1'b0;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      pages_q   <= 12'd0;
      boot_q    <= 1'b0;
      shift_q   <= 6'd0;
      rddata_q  <= 8'd0;
      rdvalid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      sync3_q   <= sync3_d;
      tick_q    <= tick_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pages_q   <= pages_d;
      boot_q    <= boot_d;
      shift_q   <= shift_d;
      rddata_q  <= rddata_d;
      rdvalid_q <= rdvalid_d;
      overrun_q <= overrun_d;
    end
  end

  assign BUSY    = (state_q != S_IDLE);
  assign DONE    = (state_q == S_FINISH);
  assign nBSS    = ~((state_q == S_SETUP) || (state_q == S_PAGE) || (state_q == S_GAP));
  assign nBSEN   = (state_q != S_PAGE);
  assign nREPEN  = (state_q != S_SETUP);
  assign nBOOTEN = BUSY ? ~boot_q : 1'b1;
  assign nSWAPEN = 1'b1;
  assign RDDATA  = rddata_q;
  assign RDVALID = rdvalid_q;
  assign OVERRUN = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_bubble_host_reader.sv
`default_nettype none
`timescale 1ns/1ps
// Randomized bench for bubble_host_reader: scoreboard of expected bytes plus
// strobe-timing monitor, CLKOUT pulses generated one by one (12 MCLK each).
module tb_bubble_host_reader;
  localparam int ST   = 2;
  localparam int PT   = 8;
  localparam int GT   = 2;
  localparam int TPER = 12;

  logic        MCLK = 1'b0;
  logic        MRST = 1'b1;
  logic        START = 1'b0;
  logic        BOOTMODE = 1'b0;
  logic [11:0] PAGECNT = 12'd0;
  logic        CLKOUT = 1'b0;
  logic        DOUT0 = 1'b1;
  logic        DOUT1 = 1'b1;
  logic        RDREADY = 1'b1;
  logic        nBSS, nBSEN, nREPEN, nBOOTEN, nSWAPEN;
  logic [7:0]  RDDATA;
  logic        RDVALID, BUSY, DONE, OVERRUN;

  bubble_host_reader #(.SETTLE_TICKS(ST), .PAGE_TICKS(PT), .GAP_TICKS(GT)) dut (
    .MCLK(MCLK), .MRST(MRST), .START(START), .BOOTMODE(BOOTMODE), .PAGECNT(PAGECNT),
    .CLKOUT(CLKOUT), .DOUT0(DOUT0), .DOUT1(DOUT1),
    .nBSS(nBSS), .nBSEN(nBSEN), .nREPEN(nREPEN), .nBOOTEN(nBOOTEN), .nSWAPEN(nSWAPEN),
    .RDDATA(RDDATA), .RDVALID(RDVALID), .RDREADY(RDREADY),
    .BUSY(BUSY), .DONE(DONE), .OVERRUN(OVERRUN)
  );

  always #10 MCLK = ~MCLK;

  int checks = 0;
  int passes = 0;
  logic [7:0] exp_q[$];
  logic cur_boot = 1'b0;
  bit force_lo = 1'b0;
  bit force_hi = 1'b0;
  int done_cnt = 0, bsen_falls = 0;
  int viol_swap = 0, viol_boot = 0, viol_repen = 0, viol_bss = 0, viol_bsen = 0, viol_donew = 0;
  logic [1:0] dir_codes[PT] = '{2'b11, 2'b10, 2'b01, 2'b00, 2'b11, 2'b11, 2'b11, 2'b11};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference byte: tick k contributes the inverted pair times 4^k.
  function automatic logic [7:0] model_byte(input logic [1:0] c0, input logic [1:0] c1,
                                            input logic [1:0] c2, input logic [1:0] c3);
    int v;
    v = (3 - int'(c0)) + (3 - int'(c1)) * 4 + (3 - int'(c2)) * 16 + (3 - int'(c3)) * 64;
    return 8'(v);
  endfunction

  // Consumer: random RDREADY, but never low for more than 7 cycles unless forced.
  initial begin
    int rcnt = 0;
    forever begin
      @(posedge MCLK); #2;
      rcnt++;
      if (force_lo) RDREADY = 1'b0;
      else if (force_hi) RDREADY = 1'b1;
      else RDREADY = ($urandom_range(0, 3) != 0) || (rcnt % 8 == 0);
    end
  end

  // Monitor: scoreboard pops plus strobe/timing rules.
  initial begin
    logic prev_bsen = 1'b1, prev_done = 1'b0, mrst_d = 1'b1;
    int low_len = 0, hi_len = 0, pages_seen = 0;
    forever begin
      @(negedge MCLK);
      if (MRST || mrst_d) begin
        prev_bsen = nBSEN; prev_done = DONE; low_len = 0; hi_len = 0; pages_seen = 0;
      end else begin
        if (nSWAPEN !== 1'b1) viol_swap++;
        if (nBOOTEN !== (BUSY ? ~cur_boot : 1'b1)) viol_boot++;
        if (nREPEN !== !(BUSY && nBSEN && pages_seen == 0)) viol_repen++;
        if (nBSS !== !(BUSY && !DONE)) viol_bss++;
        if (!nBSEN && !BUSY) viol_bsen++;
        if (DONE && prev_done) viol_donew++;
        if (DONE && !prev_done) done_cnt++;
        if (!nBSEN) begin
          if (prev_bsen) begin
            bsen_falls++;
            if (pages_seen > 0) check("gap_len_cycles", hi_len, GT * TPER);
            pages_seen++;
          end
          low_len++;
        end else begin
          if (!prev_bsen) begin
            check("page_len_cycles", low_len, PT * TPER);
            low_len = 0;
            hi_len  = 0;
          end
          hi_len++;
        end
        if (RDVALID && RDREADY) begin
          check("sb_has_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) check("rddata", RDDATA, exp_q.pop_front());
        end
        if (!BUSY) pages_seen = 0;
        prev_bsen = nBSEN;
        prev_done = DONE;
      end
      mrst_d = MRST;
    end
  end

  // One CLKOUT period; optionally fires a START (with flipped BOOTMODE) mid-access.
  task automatic tick_pulse(input logic [1:0] d, input bit inject);
    DOUT1 = d[1]; DOUT0 = d[0]; CLKOUT = 1'b1;
    for (int c = 0; c < TPER; c++) begin
      if (c == TPER / 2) CLKOUT = 1'b0;
      if (inject && c == 1) begin START = 1'b1; BOOTMODE = ~cur_boot; end
      else START = 1'b0;
      @(posedge MCLK); #3;
    end
  endtask

  // mode: 0 random data, 1 directed data, 2 random + START while busy, 3 only first byte expected
  task automatic run_access(input logic boot, input int pages, input int mode);
    int done_before;
    int falls_before;
    logic [1:0] codes[PT];
    done_before  = done_cnt;
    falls_before = bsen_falls;
    @(posedge MCLK); #3;
    START = 1'b1; BOOTMODE = boot; PAGECNT = 12'(pages); cur_boot = boot;
    @(posedge MCLK); #3;
    START = 1'b0; PAGECNT = 12'd7;
    @(negedge MCLK);
    check("busy_after_start", BUSY, 1);
    check("nbss_after_start", nBSS, 0);
    check("overrun_cleared_on_start", OVERRUN, 0);
    @(posedge MCLK); #3;
    for (int i = 0; i < ST; i++) tick_pulse(2'($urandom_range(0, 3)), (mode == 2) && (i == 1));
    for (int p = 0; p < pages; p++) begin
      for (int t = 0; t < PT; t++) codes[t] = (mode == 1) ? dir_codes[t] : 2'($urandom_range(0, 3));
      for (int b = 0; b < PT / 4; b++)
        if (mode != 3 || b == 0)
          exp_q.push_back(model_byte(codes[4*b], codes[4*b+1], codes[4*b+2], codes[4*b+3]));
      for (int t = 0; t < PT; t++) tick_pulse(codes[t], 1'b0);
      if (p < pages - 1)
        for (int g = 0; g < GT; g++) tick_pulse(2'($urandom_range(0, 3)), 1'b0);
    end
    for (int i = 0; i < 100 && done_cnt == done_before; i++) @(posedge MCLK);
    repeat (2) @(posedge MCLK);
    @(negedge MCLK);
    check("done_pulses", done_cnt - done_before, 1);
    check("nbsen_pulses", bsen_falls - falls_before, pages);
    check("idle_after_done", BUSY, 0);
  endtask

  initial begin
    logic [1:0] codes[PT];
    int done_before;
    repeat (3) @(posedge MCLK);
    #3 MRST = 1'b0;
    @(negedge MCLK);
    check("reset_strobes", {nBSS, nBSEN, nREPEN, nBOOTEN, nSWAPEN}, 5'b11111);
    check("reset_flags", {RDVALID, BUSY, DONE, OVERRUN}, 4'b0000);
    check("reset_rddata", RDDATA, 8'h00);

    // Directed single page: expects 0xE4 then 0x00.
    force_hi = 1'b1;
    run_access(1'b1, 1, 1);
    force_hi = 1'b0;

    run_access(1'b0, 3, 0);

    // Consumer stalls for a whole page: first byte held, second dropped.
    force_lo = 1'b1;
    run_access(1'b0, 1, 3);
    check("overrun_set", OVERRUN, 1);
    check("held_valid", RDVALID, 1);
    force_lo = 1'b0;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge MCLK);
    @(negedge MCLK);
    check("held_byte_drained", exp_q.size(), 0);
    check("overrun_sticky", OVERRUN, 1);
    run_access(1'b1, 1, 0);

    // Reset at page tick 5.
    force_hi = 1'b1;
    @(posedge MCLK); #3;
    START = 1'b1; BOOTMODE = 1'b1; PAGECNT = 12'd2; cur_boot = 1'b1;
    @(posedge MCLK); #3;
    START = 1'b0;
    for (int i = 0; i < ST; i++) tick_pulse(2'($urandom_range(0, 3)), 1'b0);
    for (int t = 0; t < PT; t++) codes[t] = 2'($urandom_range(0, 3));
    exp_q.push_back(model_byte(codes[0], codes[1], codes[2], codes[3]));
    for (int t = 0; t < 5; t++) tick_pulse(codes[t], 1'b0);
    MRST = 1'b1;
    @(posedge MCLK); #3;
    MRST = 1'b0;
    @(negedge MCLK);
    check("midreset_strobes", {nBSS, nBSEN, nREPEN, nBOOTEN, nSWAPEN}, 5'b11111);
    check("midreset_flags", {RDVALID, BUSY, DONE, OVERRUN}, 4'b0000);
    check("midreset_sb_empty", exp_q.size(), 0);
    force_hi = 1'b0;
    run_access(1'b0, 2, 0);

    // START with PAGECNT=0 is ignored.
    done_before = done_cnt;
    @(posedge MCLK); #3;
    START = 1'b1; PAGECNT = 12'd0;
    @(posedge MCLK); #3;
    START = 1'b0;
    repeat (4) @(negedge MCLK);
    check("zero_pagecnt_busy", BUSY, 0);
    check("zero_pagecnt_nbss", nBSS, 1);
    check("zero_pagecnt_done", done_cnt - done_before, 0);

    // START while busy must not restart or change the page count.
    run_access(1'b1, 2, 2);

    for (int r = 0; r < 4; r++) run_access(1'($urandom_range(0, 1)), $urandom_range(1, 3), 0);

    repeat (20) @(posedge MCLK);
    @(negedge MCLK);
    check("sb_empty_at_end", exp_q.size(), 0);
    check("viol_nswapen", viol_swap, 0);
    check("viol_nbooten", viol_boot, 0);
    check("viol_nrepen", viol_repen, 0);
    check("viol_nbss", viol_bss, 0);
    check("viol_nbsen_idle", viol_bsen, 0);
    check("viol_done_width", viol_donew, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish, %0d/%0d checks passed", passes, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
